ov5640_cfg_ctrl: RTL and testbench

- Sequences the OV5640 register initialisation once sensor power-up has completed (power_done high).
- Walks an external register table (ROM) and issues one SCCB write per entry to the existing sccb_master bit engine through a req/done handshake.
- Inserts a settle delay after the software-reset write, then reports completion or error to the capture pipeline.

---
 rtl/ov5640_cfg_pkg.sv | 31 +++
 rtl/ov5640_cfg_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ov5640_cfg_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov5640_cfg_pkg.sv
// Shared types and constants for the OV5640 register-table sequencer.
// Table word layout: {reg_addr[23:8], reg_data[7:0]}.
package ov5640_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_POST,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERR
  } cfg_state_t;

  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic [15:0] SRST_ADDR_DEF  = 16'h3008;
  localparam int          SRST_DELAY_DEF = 250_000;

  function automatic logic is_srst(
    input logic [15:0] addr,
    input logic [7:0]  data,
    input logic [15:0] srst_addr
  );
    return (addr == srst_addr) && data[7];
  endfunction

endpackage

// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 init sequencer: walks the register ROM, one SCCB write per entry.
// Define OV5640_CFG_RETRY_EN to retry NACKed writes up to RETRY_MAX times.
module ov5640_cfg_ctrl
  import ov5640_cfg_pkg::*;
#(
  parameter int          REG_NUM    = 252,
  parameter int          IDX_W      = 8,
  parameter logic [15:0] SRST_ADDR  = SRST_ADDR_DEF,
  parameter int          SRST_DELAY = SRST_DELAY_DEF,
  parameter int          RETRY_MAX  = 3
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             power_done,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [23:0]      tbl_data,
  output logic             sccb_req,
  output logic [15:0]      sccb_addr,
  output logic [7:0]       sccb_wdata,
  input  logic             sccb_done,
  input  logic             sccb_nack,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int DLY_W = $clog2(SRST_DELAY + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SRST_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_NUM - 1);

  if (REG_NUM < 1 || REG_NUM > (1 << IDX_W) ||
      SRST_DELAY < 1 || RETRY_MAX < 0) begin : g_bad_param
    $error("ov5640_cfg_ctrl: parameter out of range");
  end

  cfg_state_t       r_state;
  logic             r_fetch2;
  logic [DLY_W-1:0] r_dly;
  logic [IDX_W-1:0] r_idx;
  logic             r_req;
  logic [15:0]      r_addr;
  logic [7:0]       r_wdata;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

`ifdef OV5640_CFG_RETRY_EN
  localparam int RTRY_W = $clog2(RETRY_MAX + 2);
  localparam logic [RTRY_W-1:0] RTRY_LAST = RTRY_W'(RETRY_MAX);
  logic [RTRY_W-1:0] r_retry;
`endif

  logic w_last;
  logic w_srst;

  assign w_last = (r_idx == IDX_LAST);
  assign w_srst = is_srst(r_addr, r_wdata, SRST_ADDR);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state  <= S_IDLE;
      r_fetch2 <= 1'b0;
      r_dly    <= '0;
      r_idx    <= '0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef OV5640_CFG_RETRY_EN
      r_retry  <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (power_done) begin
            r_state  <= S_FETCH;
            r_idx    <= '0;
            r_fetch2 <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_FETCH: begin
          // second cycle: ROM output now reflects r_idx
          if (r_fetch2) begin
            r_fetch2 <= 1'b0;
            r_addr   <= tbl_data[ADDR_MSB:ADDR_LSB];
            r_wdata  <= tbl_data[DATA_MSB:0];
            r_req    <= 1'b1;
            r_state  <= S_ISSUE;
          end else begin
            r_fetch2 <= 1'b1;
          end
        end
        S_ISSUE: begin
`ifdef OV5640_CFG_RETRY_EN
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (sccb_done) begin
            r_req <= 1'b0;
            if (!sccb_nack) begin
              r_state <= S_POST;
            end else if (r_retry == RTRY_LAST) begin
              r_state <= S_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_retry <= r_retry + 1'b1;
            end
          end
`else
          if (sccb_done) begin
            r_req <= 1'b0;
            if (!sccb_nack) begin
              r_state <= S_POST;
            end else begin
              r_state <= S_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
`endif
        end
        S_POST: begin
          r_state <= w_srst ? S_DELAY : S_NEXT;
        end
        S_DELAY: begin
          if (r_dly == DLY_LAST) begin
            r_dly   <= '0;
            r_state <= S_NEXT;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        S_NEXT: begin
`ifdef OV5640_CFG_RETRY_EN
          r_retry <= '0;
`endif
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tbl_idx    = r_idx;
  assign sccb_req   = r_req;
  assign sccb_addr  = r_addr;
  assign sccb_wdata = r_wdata;
  assign cfg_busy   = r_busy;
  assign cfg_done   = r_done;
  assign cfg_err    = r_err;

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// Directed bench for ov5640_cfg_ctrl with a registered ROM and SCCB slave model.
// NACK expectations follow OV5640_CFG_RETRY_EN when it is defined.
module tb_ov5640_cfg_ctrl;

  localparam int IDX_W   = 8;
  localparam int ACK_LAT = 40;

  logic             sclk = 1'b0;
  logic             s_rst_n = 1'b0;
  logic             power_done = 1'b0;
  logic [IDX_W-1:0] tbl_idx;
  logic [23:0]      tbl_data;
  logic             sccb_req;
  logic [15:0]      sccb_addr;
  logic [7:0]       sccb_wdata;
  logic             sccb_done;
  logic             sccb_nack;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_err;

  ov5640_cfg_ctrl #(
    .REG_NUM   (4),
    .IDX_W     (IDX_W),
    .SRST_ADDR (16'h3008),
    .SRST_DELAY(1000),
    .RETRY_MAX (3)
  ) u_dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .power_done(power_done),
    .tbl_idx   (tbl_idx),
    .tbl_data  (tbl_data),
    .sccb_req  (sccb_req),
    .sccb_addr (sccb_addr),
    .sccb_wdata(sccb_wdata),
    .sccb_done (sccb_done),
    .sccb_nack (sccb_nack),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  logic [23:0] rom [4];
  always @(posedge sclk)
    tbl_data <= (tbl_idx < 8'd4) ? rom[tbl_idx[1:0]] : 24'h0;

  int nack_idx = -1;
  int nack_cnt = 0;
  int lat_cnt;
  int nk_given;

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sccb_done <= 1'b0;
      sccb_nack <= 1'b0;
      lat_cnt   <= 0;
      nk_given  <= 0;
    end else begin
      sccb_done <= 1'b0;
      sccb_nack <= 1'b0;
      if (sccb_req && !sccb_done) begin
        if (lat_cnt == ACK_LAT - 1) begin
          lat_cnt   <= 0;
          sccb_done <= 1'b1;
          if (int'(tbl_idx) == nack_idx && nk_given < nack_cnt) begin
            sccb_nack <= 1'b1;
            nk_given  <= nk_given + 1;
          end
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end else begin
        lat_cnt <= 0;
      end
    end
  end

  logic [23:0] req_log  [16];
  int          req_cyc  [16];
  int          done_cyc [16];
  int          nreq = 0;
  int          ndone = 0;
  logic        req_q = 1'b0;

  always @(negedge sclk) begin
    if (!s_rst_n) begin
      nreq  = 0;
      ndone = 0;
      req_q = 1'b0;
    end else begin
      if (sccb_req && !req_q && nreq < 16) begin
        req_log[nreq] = {sccb_addr, sccb_wdata};
        req_cyc[nreq] = cyc;
        nreq++;
      end
      if (sccb_done && ndone < 16) begin
        done_cyc[ndone] = cyc;
        ndone++;
      end
      req_q = sccb_req;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sclk);
    s_rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    s_rst_n = 1'b1;
  endtask

  task automatic wait_end(input int lim);
    int n = 0;
    while (!(cfg_done || cfg_err) && n < lim) begin
      @(negedge sclk);
      n++;
    end
    chk("end_reached", {31'b0, cfg_done | cfg_err}, 32'd1);
  endtask

  task automatic wait_req(input int cnt, input int lim);
    int n = 0;
    while (nreq < cnt && n < lim) begin
      @(negedge sclk);
      n++;
    end
    chk("req_reached", {31'b0, nreq >= cnt}, 32'd1);
  endtask

  task automatic load_basic();
    rom[0] = 24'h3103_11;
    rom[1] = 24'h3017_FF;
    rom[2] = 24'h3018_FC;
    rom[3] = 24'h3108_01;
  endtask

  int t0;

  initial begin
    load_basic();

    // reset state
    repeat (4) @(negedge sclk);
    chk("rst_req",  {31'b0, sccb_req}, 32'd0);
    chk("rst_busy", {31'b0, cfg_busy}, 32'd0);
    chk("rst_done", {31'b0, cfg_done}, 32'd0);
    chk("rst_err",  {31'b0, cfg_err},  32'd0);
    chk("rst_idx",  {24'b0, tbl_idx},  32'd0);
    chk("rst_addr", {8'b0, sccb_addr, sccb_wdata}, 32'd0);
    s_rst_n = 1'b1;

    // power gating
    repeat (10_000) @(negedge sclk);
    chk("gate_nreq", nreq, 32'd0);
    chk("gate_idx",  {24'b0, tbl_idx},  32'd0);
    chk("gate_busy", {31'b0, cfg_busy}, 32'd0);
    power_done = 1'b1;
    t0 = cyc;
    wait_req(1, 20);
    chk("first_lat", req_cyc[0] - t0, 32'd3);
    chk("busy_run", {31'b0, cfg_busy}, 32'd1);

    // basic run
    wait_end(3000);
    chk("base_nreq", nreq, 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("base_req%0d", i), {8'b0, req_log[i]}, {8'b0, rom[i]});
    chk("base_gap", req_cyc[1] - done_cyc[0], 32'd5);
    chk("base_done", {31'b0, cfg_done}, 32'd1);
    chk("base_busy", {31'b0, cfg_busy}, 32'd0);
    chk("base_err",  {31'b0, cfg_err},  32'd0);
    chk("base_idx",  {24'b0, tbl_idx},  32'd3);
    power_done = 1'b0;
    repeat (100) @(negedge sclk);
    chk("done_sticky", {31'b0, cfg_done}, 32'd1);
    chk("done_nreq", nreq, 32'd4);
    power_done = 1'b1;

    // soft reset delay
    rom[0] = 24'h3008_82;
    rom[1] = 24'h3103_11;
    rom[2] = 24'h3008_02;
    rom[3] = 24'h3108_01;
    do_reset();
    wait_end(5000);
    chk("srst_nreq", nreq, 32'd4);
    chk("srst_req1", {8'b0, req_log[1]}, 32'h0031_0311);
    chk("srst_gap_min", {31'b0, (req_cyc[1] - done_cyc[0]) >= 1000}, 32'd1);
    chk("srst_gap_max", {31'b0, (req_cyc[1] - done_cyc[0]) <= 1010}, 32'd1);
    chk("nodly_gap", req_cyc[3] - done_cyc[2], 32'd5);
    chk("srst_done", {31'b0, cfg_done}, 32'd1);

    // NACK handling
    load_basic();
    nack_idx = 2;
`ifdef OV5640_CFG_RETRY_EN
    nack_cnt = 2;
    do_reset();
    wait_end(3000);
    chk("rty_done", {31'b0, cfg_done}, 32'd1);
    chk("rty_err",  {31'b0, cfg_err},  32'd0);
    chk("rty_nreq", nreq, 32'd6);
    chk("rty_req4", {8'b0, req_log[4]}, 32'h0030_18FC);
    chk("rty_req5", {8'b0, req_log[5]}, 32'h0031_0801);
    nack_idx = 1;
    nack_cnt = 4;
    do_reset();
    wait_end(3000);
    chk("rty_fail_err",  {31'b0, cfg_err},  32'd1);
    chk("rty_fail_done", {31'b0, cfg_done}, 32'd0);
    chk("rty_fail_idx",  {24'b0, tbl_idx},  32'd1);
    chk("rty_fail_nreq", nreq, 32'd5);
`else
    nack_cnt = 1;
    do_reset();
    wait_end(3000);
    chk("nack_err",  {31'b0, cfg_err},  32'd1);
    chk("nack_done", {31'b0, cfg_done}, 32'd0);
    chk("nack_busy", {31'b0, cfg_busy}, 32'd0);
    chk("nack_idx",  {24'b0, tbl_idx},  32'd2);
    chk("nack_req",  {31'b0, sccb_req}, 32'd0);
    repeat (200) @(negedge sclk);
    chk("nack_nreq", nreq, 32'd3);
    chk("nack_sticky", {31'b0, cfg_err}, 32'd1);
`endif

    // reset during ISSUE of entry 1
    nack_idx = -1;
    nack_cnt = 0;
    do_reset();
    wait_req(2, 500);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("mid_req",  {31'b0, sccb_req}, 32'd0);
    chk("mid_busy", {31'b0, cfg_busy}, 32'd0);
    chk("mid_idx",  {24'b0, tbl_idx},  32'd0);
    chk("mid_addr", {8'b0, sccb_addr, sccb_wdata}, 32'd0);
    chk("mid_flags", {30'b0, cfg_done, cfg_err}, 32'd0);
    repeat (2) @(negedge sclk);
    s_rst_n = 1'b1;
    wait_end(3000);
    chk("mid_nreq", nreq, 32'd4);
    chk("mid_req0", {8'b0, req_log[0]}, 32'h0031_0311);
    chk("mid_done", {31'b0, cfg_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
